// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and FSM state encoding for the character FIFO sequencer.
// Latency: n/a. Backpressure: n/a.
package fifo_ctrl_pkg;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 256;
  localparam int CNT_W  = 9;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    LOAD    = 2'd2,
    PRESENT = 2'd3
  } state_t;
endpackage

// File: rtl/fifo_occ_counter.sv
// Up/down occupancy counter (0..DEPTH) with synchronous clear.
// Latency: count updates on the edge after inc/dec/clr. Backpressure: none.
module fifo_occ_counter
  import fifo_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_FULL)) begin
      count_d = count_q + 1'b1;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  a_no_inc_and_dec: assert property (@(posedge clk) disable iff (!rst) !(inc && dec));

endmodule

// File: rtl/fifo_ctrl.sv
// Keypad/backspace arbiter and drain sequencer for the 256-entry character FIFO; optional flush via FIFO_CTRL_FLUSH_EN.
// Latency: send at edge N gives out_valid from edge N+3; one character per 3 cycles when out_ready is held.
// Backpressure: PRESENT holds out_data until out_ready; key_ready drops when full or draining.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  output logic              key_ready,
  input  logic              del_req,
  input  logic              send_req,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_del,
  output logic              fifo_re,
`ifdef FIFO_CTRL_FLUSH_EN
  input  logic              flush_req,
  output logic              fifo_clr,
`endif
  input  logic [DATA_W-1:0] fifo_dout
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              cnt_inc, cnt_dec, cnt_clr;
  logic              empty;

  fifo_occ_counter u_occ (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .dec   (cnt_dec),
    .clr   (cnt_clr),
    .count (count)
  );

  assign empty = (count == '0);

  // Strobes are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    key_ready  = 1'b0;
    fifo_we    = 1'b0;
    fifo_del   = 1'b0;
    fifo_re    = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
`ifdef FIFO_CTRL_FLUSH_EN
    fifo_clr   = 1'b0;
`endif
    if (rst) begin
      case (state_q)
        IDLE: begin
`ifdef FIFO_CTRL_FLUSH_EN
          if (flush_req) begin
            fifo_clr = 1'b1;
            cnt_clr  = 1'b1;
          end else
`endif
          if (send_req && !empty) begin
            state_d = READ;
          end else if (del_req && !empty) begin
            fifo_del = 1'b1;
            cnt_dec  = 1'b1;
          end else begin
            key_ready = (count != CNT_FULL);
            if (key_valid && key_ready) begin
              fifo_we = 1'b1;
              cnt_inc = 1'b1;
            end
          end
        end
        READ: begin
          fifo_re = 1'b1;
          cnt_dec = 1'b1;
          state_d = LOAD;
        end
        LOAD: begin
          out_data_d = fifo_dout;
          state_d    = PRESENT;
        end
        PRESENT: begin
          out_valid = 1'b1;
          out_last  = empty;
          if (out_ready) begin
            state_d = empty ? IDLE : READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

  assign fifo_din = fifo_we ? key_data : '0;
  assign out_data = out_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 256x4 FIFO behind it.
// Vector table covers entry/delete/priority/drain; hand sequences cover fill, stall, reset, flush.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  logic              clk;
  logic              rst;
  logic              key_valid;
  logic [DATA_W-1:0] key_data;
  logic              key_ready;
  logic              del_req;
  logic              send_req;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              fifo_we;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_del;
  logic              fifo_re;
  logic [DATA_W-1:0] fifo_dout;
`ifdef FIFO_CTRL_FLUSH_EN
  logic              flush_req;
  logic              fifo_clr;
`endif

  int n_pass;
  int n_total;

  fifo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .del_req   (del_req),
    .send_req  (send_req),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .count     (count),
    .fifo_we   (fifo_we),
    .fifo_din  (fifo_din),
    .fifo_del  (fifo_del),
    .fifo_re   (fifo_re),
`ifdef FIFO_CTRL_FLUSH_EN
    .flush_req (flush_req),
    .fifo_clr  (fifo_clr),
`endif
    .fifo_dout (fifo_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural character FIFO, reset together with the controller.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [7:0]        wp, rp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0; rp <= '0; fifo_dout <= '0;
    end else begin
`ifdef FIFO_CTRL_FLUSH_EN
      if (fifo_clr) begin
        wp <= '0; rp <= '0;
      end
`endif
      if (fifo_we) begin
        mem[wp] <= fifo_din;
        wp      <= wp + 8'd1;
      end
      if (fifo_del) wp <= wp - 8'd1;
      if (fifo_re) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 8'd1;
      end
    end
  end

  typedef struct packed {
    logic kv; logic [3:0] kd; logic del; logic snd; logic ordy;
    logic [19:0] exp;
  } vec_t;
  vec_t vq[$];

  task automatic add(input int kv, input int kd, input int del, input int snd, input int ordy,
                     input int krdy, input int we, input int dl, input int re, input int ov,
                     input int last, input int od, input int bsy, input int cnt);
    vec_t v;
    v.kv = kv[0]; v.kd = kd[3:0]; v.del = del[0]; v.snd = snd[0]; v.ordy = ordy[0];
    v.exp = {krdy[0], we[0], dl[0], re[0], ov[0], last[0], od[3:0], bsy[0], cnt[8:0]};
    vq.push_back(v);
  endtask

  function automatic logic [19:0] obs();
    return {key_ready, fifo_we, fifo_del, fifo_re, out_valid, out_last, out_data, busy, count};
  endfunction

  function automatic logic [3:0] pat(input int i);
    int t;
    t = i + i / 16;
    return t[3:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic clear_inputs();
    key_valid = 1'b0; key_data = '0; del_req = 1'b0; send_req = 1'b0; out_ready = 1'b0;
`ifdef FIFO_CTRL_FLUSH_EN
    flush_req = 1'b0;
`endif
  endtask

  task automatic write_key(input logic [3:0] d);
    key_valid = 1'b1; key_data = d;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, n, cyc, bd, bl;
    n_pass = 0; n_total = 0;
    clear_inputs();
    rst = 1'b0;
    key_valid = 1'b1; key_data = 4'hF;
    #2;
    check("reset_outputs", 32'(obs()), 32'd0);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // kv kd del snd ordy | krdy we del re ov last od busy cnt
    add(1,3,0,0,0, 1,1,0,0,0,0,0,0,0);
    add(1,7,0,0,0, 1,1,0,0,0,0,0,0,1);
    add(1,1,0,0,0, 1,1,0,0,0,0,0,0,2);
    add(0,0,0,0,0, 1,0,0,0,0,0,0,0,3);
    add(0,0,1,0,0, 0,0,1,0,0,0,0,0,3);
    add(0,0,0,1,1, 0,0,0,0,0,0,0,0,2);
    add(0,0,0,0,1, 0,0,0,1,0,0,0,1,2);
    add(0,0,0,0,1, 0,0,0,0,0,0,0,1,1);
    add(0,0,0,0,1, 0,0,0,0,1,0,3,1,1);
    add(0,0,0,0,1, 0,0,0,1,0,0,3,1,1);
    add(0,0,0,0,1, 0,0,0,0,0,0,3,1,0);
    add(0,0,0,0,1, 0,0,0,0,1,1,7,1,0);
    add(0,0,0,0,0, 1,0,0,0,0,0,7,0,0);
    add(1,5,1,1,0, 1,1,0,0,0,0,7,0,0);
    add(1,9,0,0,0, 1,1,0,0,0,0,7,0,1);
    add(1,2,1,1,1, 0,0,0,0,0,0,7,0,2);
    add(0,0,0,0,1, 0,0,0,1,0,0,7,1,2);
    add(0,0,0,0,1, 0,0,0,0,0,0,7,1,1);
    add(0,0,0,0,1, 0,0,0,0,1,0,5,1,1);
    add(0,0,0,0,1, 0,0,0,1,0,0,5,1,1);
    add(0,0,0,0,1, 0,0,0,0,0,0,5,1,0);
    add(0,0,0,0,1, 0,0,0,0,1,1,9,1,0);
    add(0,0,0,0,0, 1,0,0,0,0,0,9,0,0);

    foreach (vq[i]) begin
      key_valid = vq[i].kv; key_data = vq[i].kd; del_req = vq[i].del;
      send_req = vq[i].snd; out_ready = vq[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vq[i].exp));
      @(posedge clk); #1;
    end
    clear_inputs();

    // Fill to DEPTH, then one refused key.
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      key_valid = 1'b1; key_data = pat(i);
      @(negedge clk);
      if (!(key_ready && fifo_we)) bad++;
      @(posedge clk); #1;
    end
    check("fill_accepted", 32'(bad), 32'd0);
    key_valid = 1'b1; key_data = 4'hF;
    @(negedge clk);
    check("full_key_ready", 32'(key_ready), 32'd0);
    check("full_no_we", 32'(fifo_we), 32'd0);
    check("full_count", 32'(count), 32'd256);
    @(posedge clk); #1;
    @(negedge clk);
    check("count_after_257th", 32'(count), 32'd256);
    @(posedge clk); #1;
    key_valid = 1'b0;

    send_req = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send_req = 1'b0;
    n = 0; cyc = 0; bd = 0; bl = 0;
    while (n < DEPTH && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (out_data !== pat(n)) bd++;
        if (out_last !== (n == DEPTH - 1)) bl++;
        n++;
      end
    end
    check("drain_count", 32'(n), 32'd256);
    check("drain_data", 32'(bd), 32'd0);
    check("drain_last", 32'(bl), 32'd0);
    check("drain_cycles", 32'(cyc), 32'd768);
    @(negedge clk);
    check("drain_idle", 32'({busy, count}), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Stall in PRESENT with key/del pulses that must be ignored.
    write_key(4'hA);
    write_key(4'h6);
    send_req = 1'b1;
    @(posedge clk); #1;
    send_req = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stall_reach_present", 32'(cyc), 32'd2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      key_valid = 1'b1; key_data = 4'h3; del_req = (i % 2 == 0);
      @(negedge clk);
      if (!(out_valid && out_data == 4'hA && !fifo_re && !fifo_we && !fifo_del
            && !key_ready && count == 9'd1 && !out_last)) bad++;
      @(posedge clk); #1;
    end
    check("stall_hold", 32'(bad), 32'd0);
    key_valid = 1'b0; del_req = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    check("stall_second", 32'({out_valid, out_last, out_data}), 32'({2'b11, 4'h6}));
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("stall_idle", 32'({busy, count}), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in LOAD.
    write_key(4'hC);
    write_key(4'hD);
    send_req = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send_req = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", 32'({busy, count}), 32'({1'b1, 9'd1}));
    rst = 1'b0;
    #1;
    check("mid_load_reset", 32'(obs()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    send_req = 1'b1;
    @(negedge clk);
    check("empty_send_krdy", 32'({key_ready, busy}), 32'({1'b1, 1'b0}));
    @(posedge clk); #1;
    send_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || out_valid || fifo_re) bad++;
    end
    check("empty_send_ignored", 32'(bad), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;

`ifdef FIFO_CTRL_FLUSH_EN
    for (int i = 0; i < 5; i++) write_key(4'(i));
    flush_req = 1'b1; key_valid = 1'b1; del_req = 1'b1; send_req = 1'b1;
    @(negedge clk);
    check("flush_strobes", 32'({fifo_clr, fifo_we, fifo_del, fifo_re, busy, count}),
          32'({1'b1, 4'b0000, 9'd5}));
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("flush_done", 32'({fifo_clr, count}), 32'd0);
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Sequencer and arbiter in front of the 4-bit, 256-entry character FIFO.
- Shares the FIFO write/delete side between a keypad entry source and a backspace source.
- On a send command, drains the whole FIFO to a downstream consumer over valid/ready, flagging the last character.
- Tracks its own occupancy count and does not rely on the FIFO's empty/full flags for sequencing decisions.

Parameters:
- DATA_W, 4, character width.
- DEPTH, 256, FIFO entries; must match the FIFO instance.
- CNT_W, 9, occupancy counter width; holds 0..DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  keypad character offered.
- key_data  in  DATA_W  keypad character.
- key_ready  out  1  character accepted this cycle when key_valid & key_ready.
- del_req  in  1  single-cycle backspace request.
- send_req  in  1  single-cycle start-drain request.
- out_valid  out  1  out_data holds a drained character.
- out_data  out  DATA_W  drained character.
- out_last  out  1  qualifies out_valid; final character of the drain.
- out_ready  in  1  consumer accepts.
- busy  out  1  drain in progress (state != IDLE).
- count  out  CNT_W  current occupancy.
- fifo_we  out  1  FIFO write enable.
- fifo_din  out  DATA_W  FIFO write data.
- fifo_del  out  1  FIFO write-pointer step-back.
- fifo_re  out  1  FIFO read enable.
- fifo_dout  in  DATA_W  FIFO registered read data; valid the cycle after fifo_re.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, count=0, out_data=0.
- All outputs 0, including key_ready.
- The FIFO must be reset at the same time by the top level.

States:
- IDLE, READ, LOAD, PRESENT.
- FIFO strobes (fifo_we, fifo_del, fifo_re) are combinational from state and inputs. At most one is high in any cycle.

IDLE:
- Priority: send_req, then del_req, then key write.
- send_req with count>0: go to READ. No write or delete happens that cycle; key_ready=0.
- send_req with count=0: ignored, stay IDLE, and the lower-priority requests proceed.
- del_req with count>0: fifo_del=1, count-1, key_ready=0.
- del_req with count=0: dropped, and the key write proceeds.
- key_ready = (count<DEPTH) and no accepted send or delete this cycle.
- On key_valid & key_ready: fifo_we=1, fifo_din=key_data, count+1.

READ (1 cycle):
- fifo_re=1, count-1, go to LOAD.

LOAD (1 cycle):
- out_data <= fifo_dout, go to PRESENT.

PRESENT:
- out_valid=1.
- out_last=1 iff count=0.
- out_data is held stable until the handshake.
- On out_ready: go to IDLE if count=0, else go to READ.
- No handshake: stay in PRESENT indefinitely.

Drain rules:
- During READ, LOAD and PRESENT: key_ready=0, and del_req and send_req are ignored (not queued).

Latency and throughput:
- Send accepted at edge N: out_valid is high from edge N+3.
- With out_ready held high: one character per 3 cycles.

Boundaries:
- count saturates logically because key_ready=0 at DEPTH.
- DEPTH entries are written, then 256 reads; the pointer wrap is handled by the FIFO.
- count never goes below 0.
- An asynchronous reset mid-drain aborts immediately. No out_valid is asserted after reset.

Optional Feature:
Macro: FIFO_CTRL_FLUSH_EN.
With the macro defined:
- Adds input flush_req and output fifo_clr (active-high, to the FIFO synchronous rst).
- In IDLE, flush_req has priority over all other requests: fifo_clr=1 for one cycle, count <= 0, no other strobes that cycle.
- flush_req is ignored outside IDLE.
Without the macro:
- Neither port exists and the behaviour is otherwise identical.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - DATA_W, DEPTH, CNT_W constants.
  - The state_t enum {IDLE, READ, LOAD, PRESENT}.
- One natural sub-module: fifo_occ_counter.
  - Inputs: inc, dec, clr.
  - Up/down counter, CNT_W wide, with async active-low reset.
  - Asserting inc and dec together is illegal; assert against it.

Test Plan:
1. Reset, then write keys 3, 7, 1 on consecutive cycles -> 3 fifo_we pulses, count=3, key_ready stays 1.
2. Then del_req -> fifo_del for 1 cycle, count=2. Then send_req, out_ready=1:
   - out_data 3 (out_last=0), then 7 (out_last=1).
   - First out_valid 3 cycles after send.
   - busy falls after the last handshake.
3. Fill to 256 -> key_ready=0 at count=256 and a 257th key is not accepted. Drain with out_ready=1 -> 256 outputs in write order, out_last only on the 256th.
4. del_req, key_valid and send_req together with count=2 -> send wins, no fifo_del or fifo_we, drain of 2. With count=0: send ignored, del dropped, key written, count=1.
5. During a drain, hold out_ready=0 for 10 cycles in PRESENT -> out_data stable, no fifo_re. Pulse key_valid and del_req during that time -> neither accepted.
6. Pull rst low mid-LOAD -> outputs 0 immediately and count=0. After release, a send with count=0 is ignored. With FIFO_CTRL_FLUSH_EN: flush at count=5 -> fifo_clr for 1 cycle, count=0.
